// File: rtl/vga_pkg.sv
// Shared VGA screen geometry, pixel bundle and clip helper.
// Used by the pixel sink and the drawing datapaths.
package vga_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int COLOUR_W   = 9;
  localparam int COORD_W    = X_W + Y_W;
  localparam int PIXEL_W    = COORD_W + COLOUR_W;
  localparam int GRID_PITCH = 20;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic on_screen(
    input pixel_t p,
    input int     w,
    input int     h
  );
    return (int'(p.x) < w) && (int'(p.y) < h);
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Valid/ready pixel beat from the drawing datapaths.
// master = datapath side, slave = pixel_write_sink.
interface pixel_write_sink_if;
  import vga_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_coordinates;
  logic [COLOUR_W-1:0] in_colour;

  modport master (
    output in_valid,
    output in_coordinates,
    output in_colour,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_coordinates,
    input  in_colour,
    output in_ready
  );

endinterface

// File: rtl/pixel_write_sink_fifo.sv
// Synchronous FIFO with occupancy counter, no bypass.
// Pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers pixel beats and drives the VGA adapter write port.
// Define PIXEL_WRITE_SINK_CLIP_EN to drop off-screen pixels.
module pixel_write_sink
  import vga_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  pixel_write_sink_if.slave   up,
  input  logic                sink_stall,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                fifo_empty,
  output logic [15:0]         pixel_count,
  output logic [7:0]          dropped_count
);

  localparam int AW = $clog2(DEPTH);

`ifdef PIXEL_WRITE_SINK_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  pixel_t        wr_pix;
  pixel_t        rd_pix;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW:0]   occ;
  logic          clip;
  logic          hit;
  logic          drop;

  // Ready never looks at pop, so a full FIFO stalls even while draining.
  assign up.in_ready = !full && !reset;
  assign wr_pix      = {up.in_coordinates, up.in_colour};
  assign push        = up.in_valid && up.in_ready;
  assign pop         = !empty && !sink_stall;
  assign fifo_empty  = (occ == '0);

  assign clip = CLIP_EN && !on_screen(rd_pix, SCREEN_W, SCREEN_H);
  assign hit  = pop && !clip;
  assign drop = pop && clip;

  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pix),
    .rdata (rd_pix),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // Output register: load on a visible pop, otherwise hold and drop plot.
  always_ff @(posedge clk) begin
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= hit;
      if (hit) begin
        x      <= rd_pix.x;
        y      <= rd_pix.y;
        colour <= rd_pix.colour;
      end
    end
  end

  // Saturating written / clipped pixel counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_count   <= '0;
      dropped_count <= '0;
    end else begin
      if (hit && pixel_count != 16'hFFFF)
        pixel_count <= pixel_count + 1'b1;
      if (drop && dropped_count != 8'hFF)
        dropped_count <= dropped_count + 1'b1;
    end
  end

endmodule
